// File: rtl/syn_run_ctrl_if.sv
// Purpose: bundles the board/CPU-facing signals of the run/debug controller.
//   master : the side that drives go/mode/step_count/bp_*/cnt_clr and the CPU status
//            inputs (pc, halt, jumped, is_branch, branched); it observes the outputs.
//   slave  : the controller; it drives cpu_en, running, done, bp_hit, bp_idx, cnt_*.
interface syn_run_ctrl_if #(
  parameter int unsigned NUM_BP     = 4,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned STEP_WIDTH = 16
) ();
  localparam int unsigned BP_IDX_W = $clog2(NUM_BP) | 1;

  logic                         go;
  logic [1:0]                   mode;
  logic [STEP_WIDTH-1:0]        step_count;
  logic [NUM_BP*PC_WIDTH-1:0]   bp_addr;
  logic [NUM_BP-1:0]            bp_valid;
  logic                         cnt_clr;
  logic [PC_WIDTH-1:0]          pc;
  logic                         halt;
  logic                         jumped;
  logic                         is_branch;
  logic                         branched;
  logic                         cpu_en;
  logic                         running;
  logic                         done;
  logic                         bp_hit;
  logic [BP_IDX_W-1:0]          bp_idx;
  logic [CNT_WIDTH-1:0]         cnt_cycle;
  logic [CNT_WIDTH-1:0]         cnt_jump;
  logic [CNT_WIDTH-1:0]         cnt_branch;
  logic [CNT_WIDTH-1:0]         cnt_taken;

  modport master (
    output go, mode, step_count, bp_addr, bp_valid, cnt_clr,
           pc, halt, jumped, is_branch, branched,
    input  cpu_en, running, done, bp_hit, bp_idx,
           cnt_cycle, cnt_jump, cnt_branch, cnt_taken
  );

  modport slave (
    input  go, mode, step_count, bp_addr, bp_valid, cnt_clr,
           pc, halt, jumped, is_branch, branched,
    output cpu_en, running, done, bp_hit, bp_idx,
           cnt_cycle, cnt_jump, cnt_branch, cnt_taken
  );
endinterface

// File: rtl/syn_run_ctrl.sv
// Purpose: run/debug controller for the single-cycle CPU. Gates the CPU enable in
//   free-run, single-step, N-step and run-to-breakpoint modes, and keeps saturating
//   performance counters of enabled cycles, jumps, branches and taken branches.
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - asynchronous reset, active-high
//   bus  - syn_run_ctrl_if.slave: control inputs, CPU status inputs, cpu_en (combinational),
//          running/done (state decode), bp_hit/bp_idx and the four counters (registered)
module syn_run_ctrl #(
  parameter int unsigned NUM_BP     = 4,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned STEP_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  syn_run_ctrl_if.slave  bus
);
  localparam int unsigned BP_IDX_W = $clog2(NUM_BP) | 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] remaining_q, remaining_d;
  logic                  bp_armed_q, bp_armed_d;
  logic                  bp_skip_q, bp_skip_d;
  logic                  bp_hit_q, bp_hit_d;
  logic [BP_IDX_W-1:0]   bp_idx_q, bp_idx_d;
  logic [CNT_WIDTH-1:0]  cnt_cycle_q, cnt_cycle_d;
  logic [CNT_WIDTH-1:0]  cnt_jump_q, cnt_jump_d;
  logic [CNT_WIDTH-1:0]  cnt_branch_q, cnt_branch_d;
  logic [CNT_WIDTH-1:0]  cnt_taken_q, cnt_taken_d;

  logic                  bp_any;
  logic [BP_IDX_W-1:0]   bp_match_idx;
  logic                  bp_stop;
  logic                  active;
  logic                  cpu_en_c;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic inc);
    return (inc && (v != {CNT_WIDTH{1'b1}})) ? v + CNT_WIDTH'(1) : v;
  endfunction

  // Breakpoint compare; scanning downward leaves the lowest matching index.
  always_comb begin
    bp_any       = 1'b0;
    bp_match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bus.bp_valid[i] && (bus.pc == bus.bp_addr[i*PC_WIDTH +: PC_WIDTH])) begin
        bp_any       = 1'b1;
        bp_match_idx = BP_IDX_W'(i);
      end
    end
  end

  // bp_skip lets a resume retire the instruction sitting on the breakpoint.
  assign bp_stop  = bp_armed_q & ~bp_skip_q & bp_any;
  assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign cpu_en_c = active & ~bus.halt & ~bp_stop;

  // Next-state and control register updates.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    bp_armed_d  = bp_armed_q;
    bp_skip_d   = bp_skip_q;
    bp_hit_d    = bp_hit_q;
    bp_idx_d    = bp_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          bp_hit_d   = 1'b0;
          bp_skip_d  = 1'b1;
          bp_armed_d = (bus.mode == 2'b11);
          case (bus.mode)
            2'b01: begin
              state_d     = ST_STEP;
              remaining_d = STEP_WIDTH'(1);
            end
            2'b10: begin
              state_d     = ST_STEP;
              remaining_d = (bus.step_count == '0) ? STEP_WIDTH'(1) : bus.step_count;
            end
            default: state_d = ST_RUN;
          endcase
        end
      end
      ST_RUN, ST_STEP: begin
        if (cpu_en_c) begin
          bp_skip_d = 1'b0;
          if (state_q == ST_STEP) remaining_d = remaining_q - STEP_WIDTH'(1);
        end
        // Priority: halt, then breakpoint, then pause request, then step exhaustion.
        if (bus.halt) begin
          state_d = ST_DONE;
        end else if (bp_stop) begin
          state_d  = ST_IDLE;
          bp_hit_d = 1'b1;
          bp_idx_d = bp_match_idx;
        end else if (bus.go) begin
          state_d = ST_IDLE;
        end else if ((state_q == ST_STEP) && cpu_en_c && (remaining_q == STEP_WIDTH'(1))) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Performance counters: clear beats increment, saturate at all-ones.
  always_comb begin
    cnt_cycle_d  = cnt_cycle_q;
    cnt_jump_d   = cnt_jump_q;
    cnt_branch_d = cnt_branch_q;
    cnt_taken_d  = cnt_taken_q;
    if (bus.cnt_clr) begin
      cnt_cycle_d  = '0;
      cnt_jump_d   = '0;
      cnt_branch_d = '0;
      cnt_taken_d  = '0;
    end else if (cpu_en_c) begin
      cnt_cycle_d  = sat_inc(cnt_cycle_q, 1'b1);
      cnt_jump_d   = sat_inc(cnt_jump_q, bus.jumped);
      cnt_branch_d = sat_inc(cnt_branch_q, bus.is_branch);
      cnt_taken_d  = sat_inc(cnt_taken_q, bus.branched);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      bp_armed_q   <= 1'b0;
      bp_skip_q    <= 1'b0;
      bp_hit_q     <= 1'b0;
      bp_idx_q     <= '0;
      cnt_cycle_q  <= '0;
      cnt_jump_q   <= '0;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      bp_armed_q   <= bp_armed_d;
      bp_skip_q    <= bp_skip_d;
      bp_hit_q     <= bp_hit_d;
      bp_idx_q     <= bp_idx_d;
      cnt_cycle_q  <= cnt_cycle_d;
      cnt_jump_q   <= cnt_jump_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
    end
  end

  assign bus.cpu_en     = cpu_en_c;
  assign bus.running    = active;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.bp_hit     = bp_hit_q;
  assign bus.bp_idx     = bp_idx_q;
  assign bus.cnt_cycle  = cnt_cycle_q;
  assign bus.cnt_jump   = cnt_jump_q;
  assign bus.cnt_branch = cnt_branch_q;
  assign bus.cnt_taken  = cnt_taken_q;
endmodule

// File: tb/tb_syn_run_ctrl.sv
// Directed bench for syn_run_ctrl: a 32-bit-counter instance plus a 4-bit-counter
// instance sharing the same stimulus to observe counter saturation.
module tb_syn_run_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   en_count = 0;
  int   e0;

  syn_run_ctrl_if #(.CNT_WIDTH(32)) bus ();
  syn_run_ctrl_if #(.CNT_WIDTH(4))  bus4 ();

  syn_run_ctrl #(.CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  syn_run_ctrl #(.CNT_WIDTH(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus4.go         = bus.go;
  assign bus4.mode       = bus.mode;
  assign bus4.step_count = bus.step_count;
  assign bus4.bp_addr    = bus.bp_addr;
  assign bus4.bp_valid   = bus.bp_valid;
  assign bus4.cnt_clr    = bus.cnt_clr;
  assign bus4.pc         = bus.pc;
  assign bus4.halt       = bus.halt;
  assign bus4.jumped     = bus.jumped;
  assign bus4.is_branch  = bus.is_branch;
  assign bus4.branched   = bus.branched;

  always #5 clk = ~clk;

  // Enabled-cycle tally, sampled mid-cycle where inputs are stable.
  always @(negedge clk) if (bus.cpu_en === 1'b1) en_count <= en_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.go = 1'b0; bus.mode = 2'b00; bus.step_count = '0;
    bus.bp_addr = {32'h80, 32'h40, 32'h40, 32'h40};
    bus.bp_valid = 4'b0000; bus.cnt_clr = 1'b0; bus.pc = 32'h0;
    bus.halt = 1'b0; bus.jumped = 1'b0; bus.is_branch = 1'b0; bus.branched = 1'b0;

    // Reset state
    tick();
    chk("rst_cpu_en", 64'(bus.cpu_en), 64'd0);
    chk("rst_running", 64'(bus.running), 64'd0);
    chk("rst_cnt_cycle", 64'(bus.cnt_cycle), 64'd0);
    chk("rst_bp_hit", 64'(bus.bp_hit), 64'd0);
    chk("rst_bp_idx", 64'(bus.bp_idx), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: free-run, halt after 10 enabled cycles
    bus.mode = 2'b00; bus.go = 1'b1;
    #1 chk("t1_go_cycle_en", 64'(bus.cpu_en), 64'd0);
    tick();
    bus.go = 1'b0;
    e0 = en_count;
    repeat (10) tick();
    bus.halt = 1'b1;
    #1 chk("t1_halt_cycle_en", 64'(bus.cpu_en), 64'd0);
    tick();
    chk("t1_done", 64'(bus.done), 64'd1);
    chk("t1_cnt_cycle", 64'(bus.cnt_cycle), 64'd10);
    chk("t1_en_cycles", 64'(en_count - e0), 64'd10);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    chk("t1_done_absorbing", 64'(bus.done), 64'd1);
    chk("t1_done_cpu_en", 64'(bus.cpu_en), 64'd0);
    chk("t1_cnt_frozen", 64'(bus.cnt_cycle), 64'd10);

    bus.halt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // 2: N-step of 5 with jumps on enabled cycles 2 and 4
    bus.mode = 2'b10; bus.step_count = 16'd5; bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    e0 = en_count;
    for (int i = 0; i < 5; i++) begin
      bus.jumped = (i == 1 || i == 3);
      tick();
    end
    bus.jumped = 1'b0;
    #1 chk("t2_idle_cpu_en", 64'(bus.cpu_en), 64'd0);
    chk("t2_running", 64'(bus.running), 64'd0);
    chk("t2_en_cycles", 64'(en_count - e0), 64'd5);
    chk("t2_cnt_jump", 64'(bus.cnt_jump), 64'd2);
    chk("t2_cnt_cycle", 64'(bus.cnt_cycle), 64'd5);

    // 3: single-step, then N-step with count 0
    bus.mode = 2'b01; bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    e0 = en_count;
    tick(); tick();
    chk("t3_single_en", 64'(en_count - e0), 64'd1);
    chk("t3_single_idle", 64'(bus.running), 64'd0);
    bus.mode = 2'b10; bus.step_count = 16'd0; bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    e0 = en_count;
    tick(); tick();
    chk("t3_zero_step_en", 64'(en_count - e0), 64'd1);

    // 4: run to breakpoint at 0x40 (valid entries 1 and 2 match, 0 is disabled)
    bus.bp_valid = 4'b0110; bus.pc = 32'h30; bus.mode = 2'b11; bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    e0 = en_count;
    for (int a = 32'h30; a < 32'h40; a += 4) begin
      bus.pc = 32'(a);
      tick();
    end
    bus.pc = 32'h40;
    #1 chk("t4_bp_cycle_en", 64'(bus.cpu_en), 64'd0);
    tick();
    chk("t4_bp_hit", 64'(bus.bp_hit), 64'd1);
    chk("t4_bp_idx", 64'(bus.bp_idx), 64'd1);
    chk("t4_stopped", 64'(bus.running), 64'd0);
    chk("t4_en_cycles", 64'(en_count - e0), 64'd4);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    chk("t4_resume_clears_hit", 64'(bus.bp_hit), 64'd0);
    #1 chk("t4_resume_exec_bp", 64'(bus.cpu_en), 64'd1);
    tick();
    bus.pc = 32'h44;
    #1 chk("t4_after_bp_en", 64'(bus.cpu_en), 64'd1);
    tick();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    chk("t4_paused", 64'(bus.running), 64'd0);

    // 5: free-run sitting on 0x40 must not stop (breakpoints disarmed); saturation; clear
    bus.pc = 32'h40; bus.mode = 2'b00; bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.is_branch = (i < 3);
      bus.branched  = (i < 2);
      if (i == 1) begin
        #1 chk("t5_disarmed_en", 64'(bus.cpu_en), 64'd1);
      end
      tick();
    end
    bus.is_branch = 1'b0; bus.branched = 1'b0;
    chk("t5_cnt_cycle", 64'(bus.cnt_cycle), 64'd22);
    chk("t5_cnt_branch", 64'(bus.cnt_branch), 64'd3);
    chk("t5_cnt_taken", 64'(bus.cnt_taken), 64'd2);
    chk("t5_sat4_cycle", 64'(bus4.cnt_cycle), 64'hF);
    chk("t5_w4_branch", 64'(bus4.cnt_branch), 64'd3);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    chk("t5_clr_cycle", 64'(bus.cnt_cycle), 64'd0);
    chk("t5_clr_sat4", 64'(bus4.cnt_cycle), 64'd0);
    tick(); tick();
    chk("t5_recount", 64'(bus.cnt_cycle), 64'd2);

    // 6: asynchronous reset mid-run
    #2 rst = 1'b1;
    #1 chk("t6_async_cpu_en", 64'(bus.cpu_en), 64'd0);
    chk("t6_async_cnt", 64'(bus.cnt_cycle), 64'd0);
    chk("t6_async_running", 64'(bus.running), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t6_idle_after_release", 64'(bus.running), 64'd0);
    chk("t6_idle_cpu_en", 64'(bus.cpu_en), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
